// File: rtl/adc_sample_capture_if.sv
// Readout stream from the capture buffer to the logging/transmit stage.
// master = capture block (source), slave = downstream consumer.
interface adc_sample_capture_if;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/adc_sample_capture.sv
// Pre/post-trigger capture of ADC frames into a circular buffer, unloaded oldest-first.
// Optional macro ADC_CAPTURE_FORCE_TRIG_EN adds a force_trig input for manual triggering.
module adc_sample_capture #(
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 64,
  parameter int DONE_CNT = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic [4:0]  cnt15,
  input  logic        arm,
  input  logic [11:0] threshold,
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
  input  logic        force_trig,
`endif
  output logic        busy,
  output logic        done,
  adc_sample_capture_if.master rd
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int POST_N = DEPTH - PRE_TRIG;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_PRE  = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_PRE  = (ADDR_W+1)'(PRE_TRIG);
  localparam logic [ADDR_W:0]   CNT_POST = (ADDR_W+1)'(POST_N);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ALL  = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state_reg;
  logic [4:0]        cnt15_q;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] start_addr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   fill_reg;
  logic [ADDR_W:0]   post_cnt_reg;
  logic [ADDR_W:0]   rd_cnt_reg;
  logic [11:0]       prev_reg;
  logic [11:0]       rd_data_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              done_reg;
  logic [11:0]       mem [DEPTH];

  logic stb, wr_en, crossing, trig, rd_en, xfer;

  assign stb      = (cnt15 == 5'(DONE_CNT)) && (cnt15_q != 5'(DONE_CNT));
  assign wr_en    = stb && ((state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST));
  assign crossing = (prev_reg < threshold) && (sample >= threshold);
  assign xfer     = out_valid_reg && rd.out_ready;
  // Fetch the next word whenever the output register is empty or being drained.
  assign rd_en    = (state_reg == S_READ) && (rd_cnt_reg != CNT_ALL) && (!out_valid_reg || rd.out_ready);

`ifdef ADC_CAPTURE_FORCE_TRIG_EN
  logic force_pend_reg;
  always_ff @(posedge clk) begin
    if (rst || state_reg != S_WAIT) force_pend_reg <= 1'b0;
    else if (stb && force_pend_reg) force_pend_reg <= 1'b0;
    else if (force_trig)            force_pend_reg <= 1'b1;
  end
  assign trig = stb && (crossing || force_pend_reg);
`else
  assign trig = stb && crossing;
`endif

  always_ff @(posedge clk) begin
    if (rst) cnt15_q <= '0;
    else     cnt15_q <= cnt15;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= sample;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wr_ptr_reg     <= '0;
      start_addr_reg <= '0;
      rd_ptr_reg     <= '0;
      fill_reg       <= '0;
      post_cnt_reg   <= '0;
      rd_cnt_reg     <= '0;
      prev_reg       <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (arm) begin
            state_reg    <= S_PRE;
            wr_ptr_reg   <= '0;
            fill_reg     <= '0;
            post_cnt_reg <= '0;
            prev_reg     <= 12'hFFF;
          end
        end
        S_PRE: begin
          if (stb) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            prev_reg   <= sample;
            fill_reg   <= fill_reg + CNT_ONE;
            if (fill_reg + CNT_ONE == CNT_PRE) state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (stb) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            prev_reg   <= sample;
            if (trig) begin
              post_cnt_reg   <= CNT_ONE;
              start_addr_reg <= wr_ptr_reg - PTR_PRE;
              if (POST_N == 1) begin
                state_reg  <= S_READ;
                rd_ptr_reg <= wr_ptr_reg - PTR_PRE;
                rd_cnt_reg <= '0;
              end else begin
                state_reg <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (stb) begin
            wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
            post_cnt_reg <= post_cnt_reg + CNT_ONE;
            if (post_cnt_reg + CNT_ONE == CNT_POST) begin
              state_reg  <= S_READ;
              rd_ptr_reg <= start_addr_reg;
              rd_cnt_reg <= '0;
            end
          end
        end
        S_READ: begin
          if (rd_en) begin
            rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
            rd_cnt_reg    <= rd_cnt_reg + CNT_ONE;
            out_valid_reg <= 1'b1;
            out_last_reg  <= (rd_cnt_reg == CNT_LAST);
          end else if (xfer) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
          end
          if (xfer && out_last_reg) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_reg != S_IDLE);
  assign done         = done_reg;
  assign rd.out_data  = rd_data_reg;
  assign rd.out_valid = out_valid_reg;
  assign rd.out_last  = out_last_reg;
endmodule

// File: tb/tb_adc_sample_capture.sv
// Bench for adc_sample_capture (DEPTH=16, PRE_TRIG=4): table-driven ramps, hand corner
// sequences and random captures checked against a window model computed from the sample list.
module tb_adc_sample_capture;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int POST_N   = DEPTH - PRE_TRIG;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample;
  logic [4:0]  cnt15;
  logic        arm;
  logic [11:0] threshold;
  logic        busy;
  logic        done;
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
  logic        force_trig = 1'b0;
`endif

  adc_sample_capture_if rd ();

  adc_sample_capture #(.ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .DONE_CNT(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .cnt15     (cnt15),
    .arm       (arm),
    .threshold (threshold),
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
    .force_trig(force_trig),
`endif
    .busy      (busy),
    .done      (done),
    .rd        (rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int step;
    int thr;
    bit bp;
    int exp_first;
    int exp_last;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int stim_q[$];
  int hold_q[$];
  int got_q[$];
  int cap_id = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Index of the trigger sample: first sample at or after PRE_TRIG that crosses upward.
  function automatic int model_trig(input int thr);
    for (int i = PRE_TRIG; i < stim_q.size(); i++)
      if (stim_q[i-1] < thr && stim_q[i] >= thr) return i;
    return -1;
  endfunction

  task automatic set_ramp(input int start, input int step, input int n);
    stim_q.delete();
    hold_q.delete();
    for (int i = 0; i < n; i++) begin
      stim_q.push_back((start + step * i) & 12'hFFF);
      hold_q.push_back(1);
    end
  endtask

  // Arm with a simultaneous frame strobe carrying junk that must not be captured.
  task automatic arm_dut();
    @(negedge clk);
    arm = 1'b1; cnt15 = 5'd17; sample = 12'd4000;
    @(negedge clk);
    arm = 1'b0; cnt15 = 5'd0;
    chk("busy_armed", busy, 1);
    @(negedge clk);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      sample = stim_q[i][11:0];
      cnt15  = 5'd17;
      repeat (hold_q[i]) @(negedge clk);
      cnt15 = 5'd0;
      @(negedge clk);
      cnt15 = 5'd5;
      @(negedge clk);
    end
  endtask

  task automatic collect(input bit bp, input int ti);
    int  words = 0;
    int  bubbles = 0;
    bit  prev_stall = 0;
    int  pd = 0;
    int  pl = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 600 && words < DEPTH; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_data", rd.out_data, pd);
        chk("hold_last", rd.out_last, pl);
      end
      if (words > 0 && !rd.out_valid) bubbles++;
      rd.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd.out_valid && rd.out_ready) begin
        chk("word", rd.out_data, stim_q[ti - PRE_TRIG + words]);
        chk("last", rd.out_last, (words == DEPTH - 1) ? 1 : 0);
        got_q.push_back(rd.out_data);
        words++;
      end
      prev_stall = rd.out_valid && !rd.out_ready;
      pd = rd.out_data;
      pl = rd.out_last;
    end
    chk("nwords", words, DEPTH);
    if (!bp) chk("bubbles", bubbles, 0);
    @(negedge clk);
    rd.out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", rd.out_valid, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    $display("capture %0d: thr=%0d trig_idx=%0d words=%0d first=%0d", cap_id, threshold, ti,
             words, (got_q.size() > 0) ? got_q[0] : -1);
    cap_id++;
  endtask

  task automatic run_capture(input int thr, input bit bp, output int ti);
    threshold = thr[11:0];
    ti = model_trig(thr);
    arm_dut();
    if (ti < 0) begin
      feed(stim_q.size());
      chk("busy_no_trig", busy, 1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      return;
    end
    feed(ti + POST_N);
    collect(bp, ti);
  endtask

  initial begin
    vec_t vecs[4];
    int   ti;

    vecs[0] = '{start: 0,    step: 100, thr: 1000, bp: 1'b0, exp_first: 600,  exp_last: 2100};
    vecs[1] = '{start: 0,    step: 100, thr: 1000, bp: 1'b1, exp_first: 600,  exp_last: 2100};
    vecs[2] = '{start: 50,   step: 50,  thr: 500,  bp: 1'b0, exp_first: 300,  exp_last: 1050};
    vecs[3] = '{start: 3000, step: 7,   thr: 3100, bp: 1'b1, exp_first: 3077, exp_last: 3182};

    rd.out_ready = 1'b0;
    arm = 1'b0; cnt15 = 5'd0; sample = '0; threshold = '0;

    // Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample = 12'($urandom); cnt15 = 5'($urandom); arm = 1'($urandom);
      threshold = 12'($urandom); rd.out_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rd.out_valid, 0);
    chk("rst_last", rd.out_last, 0);
    chk("rst_data", rd.out_data, 0);
    arm = 1'b0; cnt15 = 5'd0; rd.out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Table-driven ramps
    for (int v = 0; v < 4; v++) begin
      set_ramp(vecs[v].start, vecs[v].step, 40);
      run_capture(vecs[v].thr, vecs[v].bp, ti);
      if (got_q.size() == DEPTH) begin
        chk("tbl_first", got_q[0], vecs[v].exp_first);
        chk("tbl_last", got_q[DEPTH-1], vecs[v].exp_last);
      end else begin
        chk("tbl_size", got_q.size(), DEPTH);
      end
    end

    // PRE blanking: the early 0->2000 step must not trigger
    stim_q = '{0, 2000, 0, 0, 0, 2000};
    hold_q = '{1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) begin
      stim_q.push_back(100 * (i + 1));
      hold_q.push_back(1);
    end
    run_capture(1000, 1'b0, ti);
    if (got_q.size() > 0) chk("blank_first", got_q[0], 2000);

    // Strobe edge: a frame count held for 50 cycles is one sample
    stim_q = '{10, 20, 30, 40, 50, 2000};
    hold_q = '{50, 1, 1, 1, 1, 1};
    for (int i = 0; i < 12; i++) begin
      stim_q.push_back(2100 + i);
      hold_q.push_back(1);
    end
    run_capture(1000, 1'b0, ti);
    if (got_q.size() > 0) chk("hold_first", got_q[0], 20);

    // Abort in POST, then a clean capture
    set_ramp(0, 100, 40);
    threshold = 12'd1000;
    arm_dut();
    feed(13);
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", rd.out_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    set_ramp(400, 30, 40);
    run_capture(700, 1'b1, ti);

    // Random captures
    for (int r = 0; r < 6; r++) begin
      stim_q.delete();
      hold_q.delete();
      for (int i = 0; i < 60; i++) begin
        stim_q.push_back($urandom_range(0, 4095));
        hold_q.push_back($urandom_range(1, 3));
      end
      run_capture($urandom_range(1, 4095), 1'($urandom_range(0, 1)), ti);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
